// File: rtl/usb_txn_sched.sv
// Host-side sequencer for a single USB OUT or IN transaction.
// Emits token / DATA0 / ACK packets toward the encoder, waits for the
// device reply, retries on NAK, timeout or bad CRC, and reports a status.
module usb_txn_sched #(
  parameter int MAX_RETRY = 8,    // 1..15
  parameter int TIMEOUT   = 255   // 1..255
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        txn_start,
  input  logic        txn_is_in,
  input  logic [6:0]  txn_addr,
  input  logic [3:0]  txn_endp,
  input  logic [63:0] txn_data,
  output logic        txn_busy,
  output logic        txn_done,
  output logic [1:0]  txn_status,
  output logic [63:0] txn_rdata,
  output logic [98:0] pkt,
  output logic        pkt_avail,
  input  logic        pkt_sent,
  input  logic        rx_valid,
  input  logic [3:0]  rx_pid,
  input  logic        rx_crc_ok,
  input  logic [63:0] rx_data
);

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_FAIL  = 2'b01;
  localparam logic [1:0] ST_STALL = 2'b10;

  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);
  localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_TOKEN, S_DATA, S_RXWAIT, S_ACKTX, S_RETRY, S_DONE
  } state_t;

  state_t       r_state;
  logic         r_is_in;
  logic [6:0]   r_addr;
  logic [3:0]   r_endp;
  logic [63:0]  r_data;
  logic [3:0]   r_retry;
  logic [7:0]   r_timer;
  logic         r_busy;
  logic         r_done;
  logic [1:0]   r_status;
  logic [63:0]  r_rdata;
  logic [98:0]  r_pkt;
  logic         r_pkt_avail;

  logic [98:0]  w_start_pkt;
  logic [98:0]  w_token_pkt;
  logic [98:0]  w_data_pkt;
  logic [98:0]  w_ack_pkt;
  logic [3:0]   w_retry_inc;
  logic [7:0]   w_timer_inc;

  // SYNC byte, then the PID with its complement check nibble, then the body.
  function automatic logic [98:0] f_pkt(input logic [3:0] pid, input logic [82:0] body);
    return {8'h01, ~pid, pid, body};
  endfunction

  // The start token is built from the live inputs because the latches are
  // only written on the same edge that launches it.
  assign w_start_pkt = f_pkt(txn_is_in ? PID_IN : PID_OUT, {txn_addr, txn_endp, 72'd0});
  assign w_token_pkt = f_pkt(r_is_in ? PID_IN : PID_OUT, {r_addr, r_endp, 72'd0});
  assign w_data_pkt  = f_pkt(PID_DATA0, {r_data, 19'd0});
  assign w_ack_pkt   = f_pkt(PID_ACK, 83'd0);

  // Both counters saturate instead of wrapping.
  assign w_retry_inc = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
  assign w_timer_inc = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;

  assign txn_busy   = r_busy;
  assign txn_done   = r_done;
  assign txn_status = r_status;
  assign txn_rdata  = r_rdata;
  assign pkt        = r_pkt;
  assign pkt_avail  = r_pkt_avail;

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state     <= S_IDLE;
      r_is_in     <= 1'b0;
      r_addr      <= '0;
      r_endp      <= '0;
      r_data      <= '0;
      r_retry     <= '0;
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_status    <= ST_OK;
      r_rdata     <= '0;
      r_pkt       <= '0;
      r_pkt_avail <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_retry <= '0;
          if (txn_start) begin
            r_is_in     <= txn_is_in;
            r_addr      <= txn_addr;
            r_endp      <= txn_endp;
            r_data      <= txn_data;
            r_busy      <= 1'b1;
            r_pkt       <= w_start_pkt;
            r_pkt_avail <= 1'b1;
            r_state     <= S_TOKEN;
          end
        end
        S_TOKEN: begin
          if (pkt_sent) begin
            if (r_is_in) begin
              r_pkt_avail <= 1'b0;
              r_timer     <= '0;
              r_state     <= S_RXWAIT;
            end else begin
              r_pkt   <= w_data_pkt;
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (pkt_sent) begin
            r_pkt_avail <= 1'b0;
            r_timer     <= '0;
            r_state     <= S_RXWAIT;
          end
        end
        S_RXWAIT: begin
          // A reply arriving on the timeout cycle still counts as a reply.
          if (rx_valid) begin
            if (rx_crc_ok && rx_pid == PID_STALL) begin
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_status <= ST_STALL;
              r_state  <= S_DONE;
            end else if (rx_crc_ok && !r_is_in && rx_pid == PID_ACK) begin
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_status <= ST_OK;
              r_state  <= S_DONE;
            end else if (rx_crc_ok && r_is_in && rx_pid == PID_DATA0) begin
              r_rdata     <= rx_data;
              r_pkt       <= w_ack_pkt;
              r_pkt_avail <= 1'b1;
              r_state     <= S_ACKTX;
            end else begin
              r_state <= S_RETRY;
            end
          end else if (r_timer == TIMEOUT_C) begin
            r_state <= S_RETRY;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_ACKTX: begin
          if (pkt_sent) begin
            r_pkt_avail <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_status    <= ST_OK;
            r_state     <= S_DONE;
          end
        end
        S_RETRY: begin
          r_retry <= w_retry_inc;
          if (w_retry_inc == MAX_RETRY_C) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_status <= ST_FAIL;
            r_state  <= S_DONE;
          end else begin
            r_pkt       <= w_token_pkt;
            r_pkt_avail <= 1'b1;
            r_state     <= S_TOKEN;
          end
        end
        S_DONE: begin
          r_retry <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_txn_sched.sv
// Directed bench for usb_txn_sched: plays the encoder and the device side.
module tb_usb_txn_sched;
  localparam int MAX_RETRY = 8;
  localparam int TIMEOUT   = 255;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        txn_start;
  logic        txn_is_in;
  logic [6:0]  txn_addr;
  logic [3:0]  txn_endp;
  logic [63:0] txn_data;
  logic        txn_busy;
  logic        txn_done;
  logic [1:0]  txn_status;
  logic [63:0] txn_rdata;
  logic [98:0] pkt;
  logic        pkt_avail;
  logic        pkt_sent;
  logic        rx_valid;
  logic [3:0]  rx_pid;
  logic        rx_crc_ok;
  logic [63:0] rx_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  usb_txn_sched #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_b(rst_b),
    .txn_start(txn_start), .txn_is_in(txn_is_in), .txn_addr(txn_addr),
    .txn_endp(txn_endp), .txn_data(txn_data),
    .txn_busy(txn_busy), .txn_done(txn_done), .txn_status(txn_status),
    .txn_rdata(txn_rdata), .pkt(pkt), .pkt_avail(pkt_avail),
    .pkt_sent(pkt_sent), .rx_valid(rx_valid), .rx_pid(rx_pid),
    .rx_crc_ok(rx_crc_ok), .rx_data(rx_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sent();
    pkt_sent = 1'b1;
    tick();
    pkt_sent = 1'b0;
  endtask

  task automatic rx(input logic [3:0] pid, input logic crc, input logic [63:0] d);
    rx_valid = 1'b1; rx_pid = pid; rx_crc_ok = crc; rx_data = d;
    tick();
    rx_valid = 1'b0; rx_pid = 4'h0; rx_crc_ok = 1'b0; rx_data = 64'h0;
  endtask

  task automatic start(input logic is_in, input logic [6:0] a, input logic [3:0] e,
                       input logic [63:0] d);
    txn_start = 1'b1; txn_is_in = is_in; txn_addr = a; txn_endp = e; txn_data = d;
    tick();
    txn_start = 1'b0;
  endtask

  task automatic wait_avail(output bit ok);
    int c = 0;
    while (pkt_avail !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    ok = (pkt_avail === 1'b1);
  endtask

  task automatic test_reset();
    rst_b = 1'b0; txn_start = 0; txn_is_in = 0; txn_addr = 0; txn_endp = 0; txn_data = 0;
    pkt_sent = 0; rx_valid = 0; rx_pid = 0; rx_crc_ok = 0; rx_data = 0;
    tick(); tick();
    n_vec++; if (pkt_avail !== 1'b0) begin n_err++; $display("FAIL reset_avail: got %b expected 0", pkt_avail); end
    n_vec++; if (pkt !== 99'd0) begin n_err++; $display("FAIL reset_pkt: got %h expected 0", pkt); end
    n_vec++; if (txn_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", txn_busy); end
    n_vec++; if (txn_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", txn_done); end
    n_vec++; if (txn_status !== 2'b00) begin n_err++; $display("FAIL reset_status: got %b expected 00", txn_status); end
    n_vec++; if (txn_rdata !== 64'd0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", txn_rdata); end
    rst_b = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_out_basic();
    start(1'b0, 7'h05, 4'h2, 64'hA5);
    n_vec++; if (pkt_avail !== 1'b1) begin n_err++; $display("FAIL out_token_latency: got %b expected 1", pkt_avail); end
    n_vec++; if (txn_busy !== 1'b1) begin n_err++; $display("FAIL out_busy: got %b expected 1", txn_busy); end
    n_vec++; if (pkt[98:72] !== {8'h01, 8'hE1, 7'h05, 4'h2}) begin n_err++; $display("FAIL out_token_hdr: got %h expected %h", pkt[98:72], {8'h01, 8'hE1, 7'h05, 4'h2}); end
    n_vec++; if (pkt[71:0] !== 72'd0) begin n_err++; $display("FAIL out_token_pad: got %h expected 0", pkt[71:0]); end
    pulse_sent();
    n_vec++; if (pkt_avail !== 1'b1 || pkt[90:83] !== 8'hC3) begin n_err++; $display("FAIL out_data_pid: got %b/%h expected 1/c3", pkt_avail, pkt[90:83]); end
    n_vec++; if (pkt[82:19] !== 64'hA5 || pkt[18:0] !== 19'd0) begin n_err++; $display("FAIL out_data_payload: got %h expected a5", pkt[82:19]); end
    pulse_sent();
    n_vec++; if (pkt_avail !== 1'b0) begin n_err++; $display("FAIL out_rxwait_avail: got %b expected 0", pkt_avail); end
    rx(4'h2, 1'b1, 64'h0);
    n_vec++; if (txn_done !== 1'b1 || txn_status !== 2'b00) begin n_err++; $display("FAIL out_done: got %b/%b expected 1/00", txn_done, txn_status); end
    n_vec++; if (txn_busy !== 1'b0) begin n_err++; $display("FAIL out_busy_drop: got %b expected 0", txn_busy); end
    tick();
    n_vec++; if (txn_done !== 1'b0) begin n_err++; $display("FAIL out_done_pulse: got %b expected 0", txn_done); end
    $display("test_out_basic done");
  endtask

  task automatic test_in_basic();
    start(1'b1, 7'h11, 4'h1, 64'h0);
    n_vec++; if (pkt[98:72] !== {8'h01, 8'h69, 7'h11, 4'h1}) begin n_err++; $display("FAIL in_token_hdr: got %h expected %h", pkt[98:72], {8'h01, 8'h69, 7'h11, 4'h1}); end
    pulse_sent();
    n_vec++; if (pkt_avail !== 1'b0) begin n_err++; $display("FAIL in_rxwait_avail: got %b expected 0", pkt_avail); end
    rx(4'h3, 1'b1, 64'h1234);
    n_vec++; if (pkt_avail !== 1'b1 || pkt[98:83] !== 16'h01D2 || pkt[82:0] !== 83'd0) begin n_err++; $display("FAIL in_ack_pkt: got %b/%h expected 1/01d2", pkt_avail, pkt[98:83]); end
    pulse_sent();
    n_vec++; if (txn_done !== 1'b1 || txn_status !== 2'b00) begin n_err++; $display("FAIL in_done: got %b/%b expected 1/00", txn_done, txn_status); end
    n_vec++; if (txn_rdata !== 64'h1234) begin n_err++; $display("FAIL in_rdata: got %h expected 1234", txn_rdata); end
    n_vec++; if (pkt_avail !== 1'b0) begin n_err++; $display("FAIL in_ack_drop: got %b expected 0", pkt_avail); end
    tick();
    $display("test_in_basic done");
  endtask

  task automatic test_nak_retry();
    int tokens = 0;
    bit ok;
    start(1'b0, 7'h0A, 4'h3, 64'hDEAD);
    for (int a = 1; a <= 3; a++) begin
      wait_avail(ok);
      n_vec++;
      if (!ok || pkt[90:83] !== 8'hE1) begin n_err++; $display("FAIL nak_token_%0d: got %b/%h expected 1/e1", a, pkt_avail, pkt[90:83]); end
      else tokens++;
      pulse_sent();
      pulse_sent();
      if (a < 3) rx(4'hA, 1'b1, 64'h0);
      else       rx(4'h2, 1'b1, 64'h0);
    end
    n_vec++; if (txn_done !== 1'b1 || txn_status !== 2'b00) begin n_err++; $display("FAIL nak_done: got %b/%b expected 1/00", txn_done, txn_status); end
    n_vec++; if (tokens != 3) begin n_err++; $display("FAIL nak_tokens: got %0d expected 3", tokens); end
    tick();
    $display("test_nak_retry done");
  endtask

  task automatic test_in_stall_badcrc();
    start(1'b1, 7'h33, 4'h5, 64'h0);
    n_vec++; if (pkt[90:72] !== {8'h69, 7'h33, 4'h5}) begin n_err++; $display("FAIL sb_token: got %h expected %h", pkt[90:72], {8'h69, 7'h33, 4'h5}); end
    pulse_sent();
    rx(4'h3, 1'b0, 64'hBAD);
    n_vec++; if (pkt_avail !== 1'b0 || txn_done !== 1'b0) begin n_err++; $display("FAIL sb_badcrc_retry: got %b/%b expected 0/0", pkt_avail, txn_done); end
    tick();
    n_vec++; if (pkt_avail !== 1'b1 || pkt[90:83] !== 8'h69) begin n_err++; $display("FAIL sb_retoken: got %b/%h expected 1/69", pkt_avail, pkt[90:83]); end
    pulse_sent();
    rx(4'hE, 1'b1, 64'h0);
    n_vec++; if (txn_done !== 1'b1 || txn_status !== 2'b10) begin n_err++; $display("FAIL sb_stall: got %b/%b expected 1/10", txn_done, txn_status); end
    n_vec++; if (pkt_avail !== 1'b0) begin n_err++; $display("FAIL sb_no_ack: got %b expected 0", pkt_avail); end
    tick();
    $display("test_in_stall_badcrc done");
  endtask

  task automatic test_timeout();
    int tokens = 0;
    bit finished = 1'b0;
    int c;
    start(1'b0, 7'h01, 4'h0, 64'h1);
    for (int a = 0; a < 12 && !finished; a++) begin
      n_vec++;
      if (pkt_avail !== 1'b1 || pkt[90:83] !== 8'hE1) begin n_err++; $display("FAIL to_token_%0d: got %b/%h expected 1/e1", a, pkt_avail, pkt[90:83]); end
      else tokens++;
      pulse_sent();
      pulse_sent();
      c = 0;
      while (pkt_avail !== 1'b1 && txn_done !== 1'b1 && c < 600) begin
        tick();
        c++;
      end
      n_vec++;
      if (c != TIMEOUT + 2) begin n_err++; $display("FAIL to_wait_%0d: got %0d cycles expected %0d", a, c, TIMEOUT + 2); end
      if (txn_done === 1'b1) finished = 1'b1;
    end
    n_vec++; if (!finished || txn_status !== 2'b01) begin n_err++; $display("FAIL to_status: got %b/%b expected 1/01", finished, txn_status); end
    n_vec++; if (tokens != MAX_RETRY) begin n_err++; $display("FAIL to_tokens: got %0d expected %0d", tokens, MAX_RETRY); end
    tick();
    $display("test_timeout done");
  endtask

  task automatic test_busy_ignore_and_reset();
    start(1'b0, 7'h44, 4'h6, 64'h77);
    txn_start = 1'b1; txn_is_in = 1'b1; txn_addr = 7'h7F; txn_data = 64'hFF;
    tick();
    txn_start = 1'b0;
    n_vec++; if (pkt[90:72] !== {8'hE1, 7'h44, 4'h6}) begin n_err++; $display("FAIL busy_token: got %h expected %h", pkt[90:72], {8'hE1, 7'h44, 4'h6}); end
    n_vec++; if (txn_busy !== 1'b1) begin n_err++; $display("FAIL busy_flag: got %b expected 1", txn_busy); end
    pulse_sent();
    n_vec++; if (pkt[82:19] !== 64'h77) begin n_err++; $display("FAIL busy_payload: got %h expected 77", pkt[82:19]); end
    pulse_sent();
    rx(4'h2, 1'b1, 64'h0);
    n_vec++; if (txn_done !== 1'b1) begin n_err++; $display("FAIL busy_done: got %b expected 1", txn_done); end
    txn_start = 1'b1; txn_is_in = 1'b0; txn_addr = 7'h22; txn_endp = 4'h1; txn_data = 64'h99;
    tick();
    n_vec++; if (pkt_avail !== 1'b0) begin n_err++; $display("FAIL start_in_done: got %b expected 0", pkt_avail); end
    tick();
    txn_start = 1'b0;
    n_vec++; if (pkt_avail !== 1'b1 || pkt[82:76] !== 7'h22) begin n_err++; $display("FAIL start_after_done: got %b/%h expected 1/22", pkt_avail, pkt[82:76]); end
    pulse_sent();
    rst_b = 1'b0;
    tick();
    n_vec++; if (pkt_avail !== 1'b0 || pkt !== 99'd0) begin n_err++; $display("FAIL midrst_pkt: got %b/%h expected 0/0", pkt_avail, pkt); end
    n_vec++; if (txn_busy !== 1'b0 || txn_done !== 1'b0) begin n_err++; $display("FAIL midrst_flags: got %b/%b expected 0/0", txn_busy, txn_done); end
    n_vec++; if (txn_rdata !== 64'd0 || txn_status !== 2'b00) begin n_err++; $display("FAIL midrst_regs: got %h/%b expected 0/00", txn_rdata, txn_status); end
    rst_b = 1'b1;
    tick();
    $display("test_busy_ignore_and_reset done");
  endtask

  task automatic test_idle_pkt_sent();
    pkt_sent = 1'b1; rx_valid = 1'b1; rx_pid = 4'h2; rx_crc_ok = 1'b1;
    tick(); tick();
    pkt_sent = 1'b0; rx_valid = 1'b0; rx_pid = 4'h0; rx_crc_ok = 1'b0;
    n_vec++; if (pkt_avail !== 1'b0 || txn_busy !== 1'b0 || txn_done !== 1'b0) begin n_err++; $display("FAIL idle_ignore: got %b/%b/%b expected 0/0/0", pkt_avail, txn_busy, txn_done); end
    start(1'b1, 7'h12, 4'h4, 64'h0);
    n_vec++; if (pkt_avail !== 1'b1 || pkt[90:83] !== 8'h69) begin n_err++; $display("FAIL idle_then_start: got %b/%h expected 1/69", pkt_avail, pkt[90:83]); end
    $display("test_idle_pkt_sent done");
  endtask

  initial begin
    test_reset();
    test_out_basic();
    test_in_basic();
    test_nak_retry();
    test_in_stall_badcrc();
    test_timeout();
    test_busy_ignore_and_reset();
    test_idle_pkt_sent();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
